// File: rtl/result_shifter_register.sv
// Per-column result collector: buffers up to DEPTH words from the bottom of a PE
// column and drains them in capture order over a valid/ready stream.
module result_shifter_register #(
  parameter int DATASIZE = 16,
  parameter int DEPTH    = 4,
  parameter int CNTW     = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cap_en,
  input  logic [DATASIZE-1:0] in,
  input  logic                drain_start,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATASIZE-1:0] out,
  output logic                out_last,
  output logic [CNTW-1:0]     count,
  output logic                full,
  output logic                busy,
  output logic                overflow
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    COLLECT,
    DRAIN
  } state_t;

  state_t              state, state_nxt;
  logic [DATASIZE-1:0] mem [DEPTH];
  logic [IDXW-1:0]     rd;
  logic                cap_ok;
  logic                xfer;
  logic                last;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_ok    = 1'b0;
    xfer      = 1'b0;
    last      = (state == DRAIN) && (CNTW'(rd) == count - CNTW'(1));
    case (state)
      COLLECT: begin
        cap_ok = cap_en && !full;
        // A capture accepted alongside drain_start joins this drain.
        if (drain_start && (count != '0 || cap_ok)) state_nxt = DRAIN;
      end
      DRAIN: begin
        xfer = out_ready;
        if (xfer && last) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      rd       <= '0;
      overflow <= 1'b0;
      mem      <= '{default: '0};
    end else begin
      if (cap_en && (state == DRAIN || full)) overflow <= 1'b1;
      if (cap_ok) begin
        mem[count[IDXW-1:0]] <= in;
        count                <= count + CNTW'(1);
      end
      if (state == COLLECT) begin
        rd <= '0;
      end else if (xfer) begin
        rd <= rd + IDXW'(1);
        if (last) count <= '0;
      end
    end
  end

  assign busy      = (state == DRAIN);
  assign out_valid = busy;
  assign out       = busy ? mem[rd] : '0;
  assign out_last  = last;
  assign full      = (count == CNTW'(DEPTH));

endmodule

// File: tb/tb_result_shifter_register.sv
// Randomized and directed bench for result_shifter_register, checked every cycle
// against a queue-based model of the collect/drain behaviour.
module tb_result_shifter_register;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cap_en;
  logic [DW-1:0] in;
  logic          drain_start;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out;
  logic          out_last;
  logic [CW-1:0] count;
  logic          full;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer as a queue in capture order.
  logic [DW-1:0] m_q[$];
  bit            m_drain;
  int            m_rd;
  bit            m_ovf;

  result_shifter_register #(.DATASIZE(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .in(in),
    .drain_start(drain_start), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_last(out_last), .count(count), .full(full),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_q.delete();
      m_drain = 0;
      m_rd    = 0;
      m_ovf   = 0;
    end else if (!m_drain) begin
      bit acc;
      acc = cap_en && (m_q.size() < DEPTH);
      if (cap_en && !acc) m_ovf = 1;
      if (acc) m_q.push_back(in);
      if (drain_start && m_q.size() > 0) begin
        m_drain = 1;
        m_rd    = 0;
      end
    end else begin
      if (cap_en) m_ovf = 1;
      if (out_ready) begin
        if (m_rd == m_q.size() - 1) begin
          m_drain = 0;
          m_q.delete();
        end else begin
          m_rd++;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [DW-1:0] e_out;
    bit            e_last;
    e_out  = m_drain ? m_q[m_rd] : '0;
    e_last = m_drain && (m_rd == m_q.size() - 1);
    check("out_valid", 32'(out_valid), 32'(m_drain));
    check("out",       32'(out),       32'(e_out));
    check("out_last",  32'(out_last),  32'(e_last));
    check("count",     32'(count),     32'(m_q.size()));
    check("full",      32'(full),      32'(m_q.size() == DEPTH));
    check("busy",      32'(busy),      32'(m_drain));
    check("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic step(input logic c, input logic [DW-1:0] d, input logic ds, input logic rdy);
    cap_en      = c;
    in          = d;
    drain_start = ds;
    out_ready   = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++)
      step(1'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cap_en = 1'b0; in = '0; drain_start = 1'b0; out_ready = 1'b0;
    m_drain = 0; m_rd = 0; m_ovf = 0;
    #1;

    // Reset with random inputs
    do_reset();
    check("rst_out", 32'(out), 32'h0);
    check("rst_count", 32'(count), 32'h0);

    // Fill and drain
    step(1, 16'h11, 0, 0); step(1, 16'h22, 0, 0);
    step(1, 16'h33, 0, 0); step(1, 16'h44, 0, 0);
    check("fd_count", 32'(count), 32'd4);
    check("fd_full", 32'(full), 32'd1);
    step(0, 0, 1, 1);
    check("fd_w0", 32'(out), 32'h11);
    step(0, 0, 0, 1); check("fd_w1", 32'(out), 32'h22);
    step(0, 0, 0, 1); check("fd_w2", 32'(out), 32'h33);
    check("fd_nolast", 32'(out_last), 32'd0);
    step(0, 0, 0, 1); check("fd_w3", 32'(out), 32'h44);
    check("fd_last", 32'(out_last), 32'd1);
    step(0, 0, 0, 1);
    check("fd_idle_busy", 32'(busy), 32'd0);
    check("fd_idle_out", 32'(out), 32'h0);

    // Backpressure
    step(1, 16'hA, 0, 0); step(1, 16'hB, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    check("bp_hold", 32'(out), 32'hA);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("bp_b", 32'(out), 32'hB);
    check("bp_last", 32'(out_last), 32'd1);
    step(0, 0, 0, 1);
    check("bp_done", 32'(out_valid), 32'd0);

    // Overflow when full, and during drain
    for (int i = 0; i < 4; i++) step(1, DW'(i + 1), 0, 0);
    step(1, 16'h55, 0, 0);
    check("ov_count", 32'(count), 32'd4);
    check("ov_flag", 32'(overflow), 32'd1);
    do_reset();
    step(1, 16'h9, 1, 0);
    step(1, 16'h99, 0, 0);
    check("ovd_flag", 32'(overflow), 32'd1);
    check("ovd_out", 32'(out), 32'h9);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    check("empty_ds", 32'(out_valid), 32'd0);

    // Simultaneous capture and drain_start
    do_reset();
    step(1, 16'h5, 0, 0);
    step(1, 16'h6, 1, 1);
    check("sim_w0", 32'(out), 32'h5);
    step(0, 0, 0, 1);
    check("sim_w1", 32'(out), 32'h6);
    check("sim_last", 32'(out_last), 32'd1);
    step(0, 0, 0, 1);

    // Reset mid-drain
    for (int i = 0; i < 4; i++) step(1, DW'(16'h70 + i), 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    rst_n = 1'b0;
    step(0, 0, 0, 1);
    rst_n = 1'b1;
    check("rmd_valid", 32'(out_valid), 32'd0);
    check("rmd_count", 32'(count), 32'd0);
    step(1, 16'h7, 0, 0);
    step(0, 0, 1, 0);
    check("rmd_out", 32'(out), 32'h7);
    check("rmd_last", 32'(out_last), 32'd1);
    step(0, 0, 0, 1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      step(($urandom_range(0, 2) != 0), DW'($urandom),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
